// File: rtl/cache_nway.sv
// N-way set-associative, write-back, write-allocate L1 cache with tree pseudo-LRU replacement.
// Optional macro CACHE_NWAY_PERF_CNT_EN enables the hit/miss/writeback counters.
module cache_nway #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4,
    parameter int S_TAG    = 32 - S_OFFSET - S_INDEX
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    input  logic [255:0] pmem_rdata,
    output logic [255:0] pmem_wdata,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    input  logic         pmem_resp,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count,
    output logic [31:0]  writeback_count,
    output logic [1:0]   fsm_state
);
    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int WAY_W    = $clog2(NUM_WAYS);
    localparam int PLRU_W   = NUM_WAYS - 1;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [255:0]        line_q  [NUM_SETS][NUM_WAYS];
    logic [S_TAG-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [PLRU_W-1:0]   plru_q  [NUM_SETS];
    logic [WAY_W-1:0]    victim_q;

    logic [S_TAG-1:0]   req_tag;
    logic [S_INDEX-1:0] req_index;
    logic [2:0]         req_word;
    logic               req;
    logic               unused_addr_bits;

    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic               has_invalid;
    logic [WAY_W-1:0]   inv_way;
    logic [WAY_W-1:0]   victim_sel;
    logic [255:0]       hit_line;
    logic [31:0]        hit_word;
    logic [31:0]        merged_word;
    logic [255:0]       merged_line;
    logic [255:0]       victim_line;
    logic [S_TAG-1:0]   victim_tag;

    assign req_tag          = mem_address[31 -: S_TAG];
    assign req_index        = mem_address[S_OFFSET +: S_INDEX];
    assign req_word         = mem_address[4:2];
    assign req              = mem_read | mem_write;
    assign unused_addr_bits = ^mem_address[1:0];
    assign fsm_state        = state_q;

    // Tree walk: node n has children 2n+1 (left) and 2n+2 (right); bit=0 points left.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        int               node;
        logic [WAY_W-1:0] way;
        node = 0;
        way  = '0;
        for (int l = 0; l < WAY_W; l++) begin
            way  = (way << 1) | WAY_W'(bits[node]);
            node = 2 * node + 1 + int'(bits[node]);
        end
        return way;
    endfunction

    // Point every node on the path away from the touched way.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] res;
        int                node;
        logic              dir;
        res  = bits;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir       = way[WAY_W-1-l];
            res[node] = ~dir;
            node      = 2 * node + 1 + int'(dir);
        end
        return res;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_index][w] && (tag_q[req_index][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        has_invalid = 1'b0;
        inv_way     = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_index][w]) begin
                has_invalid = 1'b1;
                inv_way     = WAY_W'(w);
            end
        end
        victim_sel = has_invalid ? inv_way : plru_victim(plru_q[req_index]);
    end

    assign hit_line    = line_q[req_index][hit_way];
    assign hit_word    = hit_line[{req_word, 5'b0} +: 32];
    assign victim_line = line_q[req_index][victim_q];
    assign victim_tag  = tag_q[req_index][victim_q];

    always_comb begin
        merged_word = hit_word;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) merged_word[8*b +: 8] = mem_wdata[8*b +: 8];
        end
        merged_line = hit_line;
        merged_line[{req_word, 5'b0} +: 32] = merged_word;
    end

    // Handshakes: the CPU holds mem_read/mem_write and its operands until a one-cycle
    // mem_resp; this block holds pmem_read/pmem_write until a one-cycle pmem_resp.
    always_comb begin
        state_d      = state_q;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state_q)
            CHECK: begin
                if (req) begin
                    if (hit) begin
                        mem_resp  = 1'b1;
                        mem_rdata = hit_word;
                    end else if (valid_q[req_index][victim_sel] && dirty_q[req_index][victim_sel]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {victim_tag, req_index, {S_OFFSET{1'b0}}};
                pmem_wdata   = victim_line;
                if (pmem_resp) state_d = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_index, {S_OFFSET{1'b0}}};
                if (pmem_resp) state_d = CHECK;
            end
            default: state_d = CHECK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CHECK;
            victim_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                CHECK: begin
                    if (req && hit) begin
                        plru_q[req_index] <= plru_touch(plru_q[req_index], hit_way);
                        if (mem_write) dirty_q[req_index][hit_way] <= 1'b1;
                    end else if (req) begin
                        victim_q <= victim_sel;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) dirty_q[req_index][victim_q] <= 1'b0;
                end
                FILL: begin
                    if (pmem_resp) begin
                        valid_q[req_index][victim_q] <= 1'b1;
                        dirty_q[req_index][victim_q] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line and tag storage carries no reset; contents are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((state_q == CHECK) && req && hit && mem_write) begin
                line_q[req_index][hit_way] <= merged_line;
            end else if ((state_q == FILL) && pmem_resp) begin
                line_q[req_index][victim_q] <= pmem_rdata;
                tag_q[req_index][victim_q]  <= req_tag;
            end
        end
    end

`ifdef CACHE_NWAY_PERF_CNT_EN
    logic refill_q;

    // refill_q marks the re-check cycle right after a fill so that its hit is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            refill_q        <= 1'b0;
            hit_count       <= '0;
            miss_count      <= '0;
            writeback_count <= '0;
        end else begin
            refill_q <= (state_q == FILL) && pmem_resp;
            if ((state_q == CHECK) && req && hit && !refill_q && (hit_count != '1))
                hit_count <= hit_count + 32'd1;
            if ((state_q == CHECK) && (state_d != CHECK) && (miss_count != '1))
                miss_count <= miss_count + 32'd1;
            if ((state_q == WRITEBACK) && pmem_resp && (writeback_count != '1))
                writeback_count <= writeback_count + 32'd1;
        end
    end
`else
    assign hit_count       = '0;
    assign miss_count      = '0;
    assign writeback_count = '0;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: vector table for single accesses, hand sequences for reset cases.
// A behavioural line adapter with its own backing store answers fills and absorbs writebacks.
module tb_cache_nway;
    localparam logic [1:0] OP_RD = 2'd0;
    localparam logic [1:0] OP_WR = 2'd1;
    localparam logic [1:0] OP_RW = 2'd2;
    localparam int ADAPT_LAT = 3;
    localparam int MAX_WAIT  = 100;

    typedef struct {
        logic [1:0]   op;
        logic [31:0]  addr;
        logic [3:0]   be;
        logic [31:0]  wdata;
        logic [31:0]  exp_rdata;
        int           exp_lat;
        logic         exp_wb;
        logic [31:0]  exp_wb_addr;
        logic [255:0] exp_wb_line;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [255:0] pmem_rdata;
    logic [255:0] pmem_wdata;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic         pmem_resp;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
    logic [31:0]  writeback_count;
    logic [1:0]   fsm_state;

    cache_nway dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_rdata      (pmem_rdata),
        .pmem_wdata      (pmem_wdata),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_resp       (pmem_resp),
        .hit_count       (hit_count),
        .miss_count      (miss_count),
        .writeback_count (writeback_count),
        .fsm_state       (fsm_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking state ----------------
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [32:0]  exp_q[$];
    logic [255:0] mem_model [logic [31:0]];
    logic [255:0] last_wb_line;
    int           adapt_cnt;
    bit           mon_en;
    bit           viol_both;
    bit           viol_resp;
    bit           viol_rdata;
    vec_t         main_vecs[$];
    vec_t         post_vecs[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [255:0] fill_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hC000_0000 | (la + 32'(i * 4));
        if (la == 32'h0) l[63:32] = 32'hDEAD_BEEF;
        return l;
    endfunction

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata, input int exp_lat,
                                input logic exp_wb, input logic [31:0] exp_wb_addr,
                                input logic [255:0] exp_wb_line);
        vec_t v;
        v.op = op; v.addr = addr; v.be = be; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
        v.exp_wb = exp_wb; v.exp_wb_addr = exp_wb_addr; v.exp_wb_line = exp_wb_line;
        return v;
    endfunction

    // Scoreboard: each adapter transaction {is_write, line address} must match the queue head.
    task automatic sb_pmem(input logic [32:0] act);
        logic [32:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL pmem_txn: got %0h expected no transaction", act);
        end else begin
            exp = exp_q.pop_front();
            check("pmem_txn", {223'b0, act}, {223'b0, exp});
        end
    endtask

    // ---------------- line adapter ----------------
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        adapt_cnt  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pmem_resp = 1'b0;
                adapt_cnt = 0;
            end else begin
                if (pmem_resp) begin
                    pmem_resp = 1'b0;
                    adapt_cnt = 0;
                end
                if (pmem_read || pmem_write) begin
                    adapt_cnt++;
                    if (adapt_cnt == ADAPT_LAT) begin
                        pmem_resp = 1'b1;
                        sb_pmem({pmem_write, pmem_address});
                        if (pmem_write) begin
                            mem_model[pmem_address] = pmem_wdata;
                            last_wb_line = pmem_wdata;
                        end else begin
                            pmem_rdata = mem_model.exists(pmem_address) ? mem_model[pmem_address]
                                                                        : fill_line(pmem_address);
                        end
                    end
                end else begin
                    adapt_cnt = 0;
                end
            end
        end
    end

    // ---------------- sticky protocol monitors ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (pmem_read && pmem_write) viol_both = 1'b1;
            if (mem_resp && (fsm_state != 2'd0)) viol_resp = 1'b1;
            if (!mem_resp && (mem_rdata != 32'h0)) viol_rdata = 1'b1;
        end
    end

    // ---------------- driver ----------------
    task automatic apply(input vec_t v, input string tag);
        logic [31:0] rd;
        int          lat;
        bit          got;
        if (v.exp_wb) exp_q.push_back({1'b1, v.exp_wb_addr});
        if (v.exp_lat > 1) exp_q.push_back({1'b0, v.addr & ~32'h1F});
        @(posedge clk); #1;
        mem_read        = (v.op == OP_RD) || (v.op == OP_RW);
        mem_write       = (v.op != OP_RD);
        mem_address     = v.addr;
        mem_byte_enable = v.be;
        mem_wdata       = v.wdata;
        lat = 0;
        got = 1'b0;
        rd  = '0;
        while (!got && (lat < MAX_WAIT)) begin
            @(negedge clk);
            lat++;
            if (mem_resp) begin
                got = 1'b1;
                rd  = mem_rdata;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        if (!got) begin
            n_checks++;
            $display("FAIL %s_timeout: got no mem_resp in %0d cycles expected a response", tag, MAX_WAIT);
            exp_q.delete();
        end else begin
            check({tag, "_lat"}, 256'(lat), 256'(v.exp_lat));
            if (v.op == OP_RD) check({tag, "_rdata"}, {224'b0, rd}, {224'b0, v.exp_rdata});
            if (v.exp_lat > 1) check({tag, "_pmem_pending"}, 256'(exp_q.size()), 256'(0));
            if (v.exp_wb) check({tag, "_wb_line"}, last_wb_line, v.exp_wb_line);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        logic [255:0] wb0, wb100, wb500, wb700;
        logic [31:0]  exp_hits, exp_miss, exp_wbc;

        wb0   = fill_line(32'h000); wb0[95:64]  = 32'hC000_5678;
        wb100 = fill_line(32'h100); wb100[31:0] = 32'hAABB_CCDD;
        wb500 = fill_line(32'h500);
        wb700 = fill_line(32'h700); wb700[31:0] = 32'h5566_0700;

        // Set 0 of a 4-way cache; PLRU is traced by hand between lines.
        main_vecs.push_back(mk(OP_RD, 32'h004, 4'h0, 32'h0, 32'hDEAD_BEEF, 5, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h004, 4'h0, 32'h0, 32'hDEAD_BEEF, 1, 0, 0, '0));
        main_vecs.push_back(mk(OP_WR, 32'h008, 4'b0011, 32'h1234_5678, 32'h0, 1, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h008, 4'h0, 32'h0, 32'hC000_5678, 1, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h100, 4'h0, 32'h0, 32'hC000_0100, 5, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h204, 4'h0, 32'h0, 32'hC000_0204, 5, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h30C, 4'h0, 32'h0, 32'hC000_030C, 5, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h000, 4'h0, 32'h0, 32'hC000_0000, 1, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h300, 4'h0, 32'h0, 32'hC000_0300, 1, 0, 0, '0));
        // PLRU victim is the way holding 0x100, clean
        main_vecs.push_back(mk(OP_RD, 32'h400, 4'h0, 32'h0, 32'hC000_0400, 5, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h200, 4'h0, 32'h0, 32'hC000_0200, 1, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h100, 4'h0, 32'h0, 32'hC000_0100, 8, 1, 32'h000, wb0));
        main_vecs.push_back(mk(OP_WR, 32'h100, 4'hF, 32'hAABB_CCDD, 32'h0, 1, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h404, 4'h0, 32'h0, 32'hC000_0404, 1, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h300, 4'h0, 32'h0, 32'hC000_0300, 1, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h500, 4'h0, 32'h0, 32'hC000_0500, 8, 1, 32'h100, wb100));
        main_vecs.push_back(mk(OP_RD, 32'h100, 4'h0, 32'h0, 32'hAABB_CCDD, 5, 0, 0, '0));
        main_vecs.push_back(mk(OP_WR, 32'h500, 4'h0, 32'hFFFF_FFFF, 32'h0, 1, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h404, 4'h0, 32'h0, 32'hC000_0404, 1, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h100, 4'h0, 32'h0, 32'hAABB_CCDD, 1, 0, 0, '0));
        // zero byte-enable write still marked the line dirty
        main_vecs.push_back(mk(OP_RD, 32'h600, 4'h0, 32'h0, 32'hC000_0600, 8, 1, 32'h500, wb500));
        main_vecs.push_back(mk(OP_RW, 32'h600, 4'hF, 32'h1122_3344, 32'h0, 1, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h600, 4'h0, 32'h0, 32'h1122_3344, 1, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h61C, 4'h0, 32'h0, 32'hC000_061C, 1, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h0E4, 4'h0, 32'h0, 32'hC000_00E4, 5, 0, 0, '0));
        main_vecs.push_back(mk(OP_RD, 32'h0E4, 4'h0, 32'h0, 32'hC000_00E4, 1, 0, 0, '0));

        post_vecs.push_back(mk(OP_RD, 32'h700, 4'h0, 32'h0, 32'hC000_0700, 5, 0, 0, '0));
        post_vecs.push_back(mk(OP_WR, 32'h700, 4'b1100, 32'h5566_7788, 32'h0, 1, 0, 0, '0));
        post_vecs.push_back(mk(OP_RD, 32'h700, 4'h0, 32'h0, 32'h5566_0700, 1, 0, 0, '0));
        post_vecs.push_back(mk(OP_RD, 32'h104, 4'h0, 32'h0, 32'hC000_0104, 5, 0, 0, '0));
        post_vecs.push_back(mk(OP_RD, 32'h200, 4'h0, 32'h0, 32'hC000_0200, 5, 0, 0, '0));
        post_vecs.push_back(mk(OP_RD, 32'h300, 4'h0, 32'h0, 32'hC000_0300, 5, 0, 0, '0));
        post_vecs.push_back(mk(OP_RD, 32'h800, 4'h0, 32'h0, 32'hC000_0800, 8, 1, 32'h700, wb700));

        // reset
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = '0; mem_address = '0; mem_wdata = '0;
        mon_en = 1'b0; viol_both = 1'b0; viol_resp = 1'b0; viol_rdata = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_mem_resp", mem_resp, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_pmem_read", pmem_read, 0);
        check("rst_pmem_write", pmem_write, 0);
        check("rst_pmem_address", pmem_address, 0);
        check("rst_state", fsm_state, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);

        foreach (main_vecs[i]) apply(main_vecs[i], $sformatf("v%0d", i));

        // reset during a fill abandons it
        @(posedge clk); #1;
        mem_read = 1'b1; mem_address = 32'h700;
        @(negedge clk);
        check("mf_miss_cycle_read", pmem_read, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mf_fill_read", pmem_read, 1);
        check("mf_fill_addr", pmem_address, 32'h700);
        @(posedge clk); #1;
        rst = 1'b1; mem_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mf_read_dropped", pmem_read, 0);
        check("mf_state", fsm_state, 0);
        check("mf_mem_resp", mem_resp, 0);
        check("mf_counters_cleared", miss_count, 0);

        // cold again after reset, then a dirty eviction in set 0
        foreach (post_vecs[i]) apply(post_vecs[i], $sformatf("p%0d", i));

`ifdef CACHE_NWAY_PERF_CNT_EN
        exp_hits = 32'd2; exp_miss = 32'd5; exp_wbc = 32'd1;
`else
        exp_hits = 32'd0; exp_miss = 32'd0; exp_wbc = 32'd0;
`endif
        @(negedge clk);
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_miss);
        check("writeback_count", writeback_count, exp_wbc);
        check("pmem_read_write_exclusive", viol_both, 0);
        check("no_resp_outside_check", viol_resp, 0);
        check("rdata_zero_when_idle", viol_rdata, 0);
        check("pmem_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cache_nway.md
Name: cache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate L1 cache.
- Successor to the fixed 2-way, 8-set cache. Way count and set count are generic, and victim selection uses tree pseudo-LRU.
- Sits between the CPU memory port (32-bit word, byte enables) and the cacheline adapter (256-bit line).
- Tag, valid, dirty, PLRU and data arrays are flip-flop based and read combinationally, so hits complete in one cycle.

Parameters:
- S_OFFSET, 5, byte-offset bits. Fixed at 5: 32-byte, 256-bit line.
- S_INDEX, 3, set-index bits. NUM_SETS = 2**S_INDEX. Legal range 1..6.
- NUM_WAYS, 4, associativity. Power of two, 2..8.
- S_TAG, 32-S_OFFSET-S_INDEX, tag width (derived).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_byte_enable  in  4  byte lanes for write.
- mem_address  in  32  byte address; held stable during request.
- mem_wdata  in  32  write word.
- mem_rdata  out  32  read word; valid when mem_resp=1, else 0.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_rdata  in  256  fill line from adapter.
- pmem_wdata  out  256  writeback line.
- pmem_address  out  32  line address, low 5 bits always 0.
- pmem_read  out  1  fill request; held until pmem_resp.
- pmem_write  out  1  writeback request; held until pmem_resp.
- pmem_resp  in  1  adapter completion pulse.

Behaviour:
- Reset (rst=1 at edge):
  - All valid, dirty and PLRU bits clear; FSM to CHECK.
  - mem_resp, pmem_read, pmem_write, mem_rdata all 0. pmem_address is 0 while idle in CHECK.
  - Data and tag arrays are not reset.
- Reset mid-operation: transaction abandoned, outputs drop the cycle after the reset edge, no array writes.
- Address split: tag = addr[31:S_OFFSET+S_INDEX], index = addr[S_OFFSET+S_INDEX-1:S_OFFSET], word = addr[4:2].
- Hit: some way w has valid[w][index]=1 and tag match. At most one way matches by construction.
- FSM states: CHECK, WRITEBACK, FILL.
- CHECK:
  - No request: idle.
  - Read hit: mem_resp=1 the same cycle, mem_rdata = word of way w.
  - Write hit: mem_resp=1 the same cycle. At the edge, merge mem_wdata into the word per byte enable and set dirty[w]=1. A write with mem_byte_enable=0 still responds and still sets dirty.
  - Any hit updates PLRU at the edge so that w becomes most-recently-used.
  - Both mem_read and mem_write high: treated as a write.
  - Miss: select victim v. If v is valid and dirty, go to WRITEBACK; else go to FILL. Register v for the miss duration.
- Victim choice: lowest-numbered invalid way if any; otherwise the tree-PLRU way (NUM_WAYS-1 bits per set, standard binary tree, bit=0 points left).
- WRITEBACK:
  - pmem_write=1, pmem_address={tag[v],index,5'b0}, pmem_wdata=line[v].
  - On pmem_resp: clear dirty[v], go to FILL.
- FILL:
  - pmem_read=1, pmem_address={req tag,index,5'b0}.
  - On pmem_resp: line[v]=pmem_rdata, tag[v]=req tag, valid[v]=1, dirty[v]=0, go to CHECK.
  - The re-check hits and responds on the next cycle.
  - No PLRU update on fill; the re-check hit updates it.
- Latency, clean miss: FILL cycles until pmem_resp, plus 1 CHECK cycle.
- Latency, dirty miss: WRITEBACK cycles plus FILL cycles plus 1 CHECK cycle.
- pmem_read and pmem_write are never high together. Both deassert the cycle after pmem_resp.
- mem_resp is never asserted in WRITEBACK or FILL.
- Request signals changing before mem_resp: undefined.

Optional Feature:
- Macro CACHE_NWAY_PERF_CNT_EN.
- Defined: three 32-bit outputs hit_count, miss_count, writeback_count, cleared by rst, saturating at 32'hFFFFFFFF.
  - hit_count increments per mem_resp on a first-look hit. The re-check hit after a fill is not counted.
  - miss_count increments on CHECK→{WRITEBACK,FILL}.
  - writeback_count increments on WRITEBACK→FILL.
- Not defined: ports remain present, tied to 0, no counter logic.

Test Plan:
- Reset, then read 0x0000_0004 → pmem_read=1, pmem_address=0x0000_0000. Adapter returns line with word1=0xDEADBEEF after 3 cycles. mem_resp 1 cycle after pmem_resp with mem_rdata=0xDEADBEEF. Immediate re-read gives mem_resp the same cycle.
- Write 0x0000_0008, be=4'b0011, wdata=0x12345678 to a resident line, then read → 0xXXXX5678, where the upper bytes keep the old value. dirty set.
- With defaults, fill 4 lines mapping to index 0 (0x000, 0x100, 0x200, 0x300), then access 0x000. Miss on 0x400 → victim is the PLRU way (way holding 0x100), no writeback since clean.
- Dirty eviction: write 0x100, fill ways until 0x100 is victim, access 0x500 → pmem_write with pmem_address=0x100 and the modified line, then pmem_read 0x500.
- Assert rst during FILL → pmem_read=0 next cycle, line not valid; later read of the same address misses again.
- With CACHE_NWAY_PERF_CNT_EN: 1 cold miss + 2 hits + 1 dirty eviction → hit_count=2, miss_count=2, writeback_count=1.
